// File: rtl/fpu_pipe_ctl.sv
// FP execution-pipeline controller: launches operands into external add/mul pipes,
// tracks dest/write/class through E1..En, sequences the iterative div/sqrt unit.
module fpu_pipe_ctl #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned STAGES    = 3,
  parameter int unsigned RN        = 5,
  parameter int unsigned DS_CYCLES = 12
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           fc,
  input  logic [RN-1:0]        fd,
  input  logic                 wf,
  input  logic                 ein1,
  input  logic                 ein2,
  input  logic [WIDTH-1:0]     add_res,
  input  logic [WIDTH-1:0]     mul_res,
  input  logic [WIDTH-1:0]     ds_res,
  output logic                 e,
  output logic                 st_ds,
  output logic                 ds_start,
  output logic                 ds_op,
  output logic [WIDTH-1:0]     efa,
  output logic [WIDTH-1:0]     efb,
  output logic                 sub,
  output logic [STAGES*RN-1:0] stg_n,
  output logic [STAGES-1:0]    stg_w,
  output logic [WIDTH-1:0]     ed,
  output logic [WIDTH-1:0]     wd,
  output logic [RN-1:0]        wn,
  output logic                 ww,
  output logic [4:0]           ds_cnt
);

  localparam logic [4:0] DS_LOAD = 5'(DS_CYCLES);
  localparam logic [1:0] CLS_ADD = 2'd0;
  localparam logic [1:0] CLS_MUL = 2'd1;
  localparam logic [1:0] CLS_DS  = 2'd2;

  logic [RN-1:0]     n_q [STAGES];
  logic [1:0]        c_q [STAGES];
  logic [STAGES-1:0] w_q;
  logic [WIDTH-1:0]  ds_q;
  logic              op_valid;
  logic              ds_req;
  logic [1:0]        id_cls;

  // ID-stage decode
  always_comb begin
    op_valid = 1'b0;
    id_cls   = CLS_ADD;
    case (fc)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_valid = 1'b1;
      default:                                op_valid = 1'b0;
    endcase
    if (fc[2])      id_cls = CLS_DS;
    else if (fc[1]) id_cls = CLS_MUL;
  end

  assign ds_req   = wf & fc[2] & ~fc[1];
  assign st_ds    = ds_req & (ds_cnt != 5'd1);
  assign e        = ein1 & ~st_ds;
  assign ds_start = ds_req & ein1 & (ds_cnt == 5'd0);
  assign ds_op    = fc[0];

  // E1 write enable is cancelled combinationally by ein2; later stages carry it
  always_comb begin
    stg_w    = w_q;
    stg_w[0] = w_q[0] & ein2;
  end

  always_comb begin
    ed = ds_q;
    case (c_q[STAGES-1])
      CLS_ADD: ed = add_res;
      CLS_MUL: ed = mul_res;
      default: ed = ds_q;
    endcase
  end

  // E1 operand and tag registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      efa    <= '0;
      efb    <= '0;
      sub    <= 1'b0;
      n_q[0] <= '0;
      c_q[0] <= '0;
      w_q[0] <= 1'b0;
    end else if (e) begin
      efa    <= a;
      efb    <= b;
      sub    <= (fc == 3'b001);
      n_q[0] <= fd;
      c_q[0] <= id_cls;
      w_q[0] <= wf & op_valid;
    end
  end

  for (genvar k = 1; k < STAGES; k++) begin : g_stage
    always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
        n_q[k] <= '0;
        c_q[k] <= '0;
        w_q[k] <= 1'b0;
      end else if (e) begin
        n_q[k] <= n_q[k-1];
        c_q[k] <= c_q[k-1];
        w_q[k] <= stg_w[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg_n
    assign stg_n[k*RN +: RN] = n_q[k];
  end

  // Writeback stage
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wd <= '0;
      wn <= '0;
      ww <= 1'b0;
    end else if (e) begin
      wd <= ed;
      wn <= n_q[STAGES-1];
      ww <= w_q[STAGES-1];
    end
  end

  // Div/sqrt stall counter; at 1 the result waits for the pipeline to advance
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ds_cnt <= '0;
      ds_q   <= '0;
    end else if (ds_cnt == 5'd0) begin
      if (ds_req & ein1) ds_cnt <= DS_LOAD;
    end else if (ds_cnt > 5'd1) begin
      ds_cnt <= ds_cnt - 5'd1;
    end else if (e) begin
      ds_q   <= ds_res;
      ds_cnt <= 5'd0;
    end
  end

endmodule
